// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-addressed SRAM port between the fetch
// requester (read-only) and the data requester (read/write). The data port
// has fixed priority. A starvation counter forces a fetch win after
// STARVE_MAX consecutive losses. Each access runs IDLE -> ISSUE -> (WAIT) ->
// RESP, and completion is signalled with a one-cycle ack.
module mem_port_arbiter #(
  parameter int AW         = 7,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          busy,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(RD_LAT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic          grant_if;
  logic          grant_wr;
  logic          starve_full;
  logic          if_win;

  // The output enable is never used to tristate Q, so it is held active.
  assign OEN = 1'b0;

  // Arbitration: the data port wins unless fetch has lost too many times in a row.
  always_comb begin
    starve_full = (starve_cnt == STARVE_TOP);
    if_win      = if_req & (~dm_req | starve_full);
  end

  // Access sequencer: grant, one-cycle SRAM strobe, read-latency wait, ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      grant_if   <= 1'b0;
      grant_wr   <= 1'b0;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      A          <= '0;
      D          <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            grant_if <= if_win;
            grant_wr <= ~if_win & dm_wr;
            CEN      <= 1'b0;
            WEN      <= ~(~if_win & dm_wr);
            busy     <= 1'b1;
            state    <= ISSUE;
            if (if_win) begin
              A          <= if_addr;
              starve_cnt <= '0;
            end else begin
              // D only ever carries data-port write data; a fetch leaves it alone.
              A <= dm_addr;
              D <= dm_wdata;
              if (if_req && !starve_full) begin
                starve_cnt <= starve_cnt + SW'(1);
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // The SRAM samples at this edge; A and D hold for the rest of the access.
          CEN <= 1'b1;
          WEN <= 1'b1;
          if (grant_wr) begin
            dm_ack <= 1'b1;
            state  <= RESP;
          end else begin
            cnt   <= LAT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            if (grant_if) begin
              if_rdata <= Q;
              if_ack   <= 1'b1;
            end else begin
              dm_rdata <= Q;
              dm_ack   <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          CEN   <= 1'b1;
          WEN   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share the
// same stimulus. Each one has its own behavioural SRAM and its own
// transaction-level reference model, checked every cycle. Directed tables
// and sequences are applied first, followed by randomized traffic.
module tb_mem_port_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int SM   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] if_addr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;

  logic          if_ack   [2];
  logic          dm_ack   [2];
  logic          busy     [2];
  logic          cen      [2];
  logic          wen      [2];
  logic          oen      [2];
  logic [AW-1:0] a        [2];
  logic [DW-1:0] d        [2];
  logic [DW-1:0] q        [2];
  logic [DW-1:0] if_rdata [2];
  logic [DW-1:0] dm_rdata [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input logic [6:0] ad);
    return {8'hA5, 1'b0, ad, 8'h3C, 1'b1, ~ad};
  endfunction

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT0), .STARVE_MAX(SM)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]), .busy(busy[0]),
    .CEN(cen[0]), .WEN(wen[0]), .OEN(oen[0]), .A(a[0]), .D(d[0]), .Q(q[0])
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT1), .STARVE_MAX(SM)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]), .busy(busy[1]),
    .CEN(cen[1]), .WEN(wen[1]), .OEN(oen[1]), .A(a[1]), .D(d[1]), .Q(q[1])
  );

  // Behavioural SRAMs: sample on CEN=0; read data walks a delay line so that
  // Q is valid only RD_LAT edges after the sampling edge (garbage otherwise).
  logic [31:0] mem  [2][128];
  logic [31:0] pipe [2][3];
  bit          init_done;

  // SRAM storage and read pipeline for both instances.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 128; j++)
          mem[i][j] <= init_word(7'(j));
      init_done <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (!cen[i] && !wen[i]) mem[i][a[i]] <= d[i];
    end
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= (!cen[i] && wen[i]) ? mem[i][a[i]] : 32'hBAD0BAD0;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end

  assign q[0] = pipe[0][LAT0-1];
  assign q[1] = pipe[1][LAT1-1];

  // Reference model: one transaction at a time, timed by edges since grant.
  bit          m_active [2];
  int          m_k      [2];
  int          m_ackk   [2];
  bit          m_is_if  [2];
  bit          m_wr     [2];
  logic [6:0]  m_addr   [2];
  int          m_starve [2];
  bit          e_cen [2], e_wen [2], e_if_ack [2], e_dm_ack [2], e_busy [2];
  logic [6:0]  e_a [2];
  logic [31:0] e_d [2], e_if_rdata [2], e_dm_rdata [2];
  logic [31:0] refmem [2][128];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    int lat;
    bit if_win;
    lat = (i == 0) ? LAT0 : LAT1;
    if (rst) begin
      m_active[i] = 1'b0; m_starve[i] = 0;
      e_cen[i] = 1'b1; e_wen[i] = 1'b1; e_a[i] = '0; e_d[i] = '0;
      e_if_ack[i] = 1'b0; e_dm_ack[i] = 1'b0; e_busy[i] = 1'b0;
      e_if_rdata[i] = '0; e_dm_rdata[i] = '0;
    end else if (m_active[i]) begin
      m_k[i]++;
      e_cen[i] = 1'b1;
      e_wen[i] = 1'b1;
      e_if_ack[i] = (m_k[i] == m_ackk[i]) && m_is_if[i];
      e_dm_ack[i] = (m_k[i] == m_ackk[i]) && !m_is_if[i];
      if (m_k[i] == m_ackk[i] && !m_wr[i]) begin
        if (m_is_if[i]) e_if_rdata[i] = refmem[i][m_addr[i]];
        else            e_dm_rdata[i] = refmem[i][m_addr[i]];
      end
      if (m_k[i] > m_ackk[i]) begin
        m_active[i] = 1'b0;
        e_busy[i]   = 1'b0;
      end
    end else begin
      e_if_ack[i] = 1'b0;
      e_dm_ack[i] = 1'b0;
      if (if_req || dm_req) begin
        if_win = if_req && (!dm_req || m_starve[i] == SM);
        if (if_win) m_starve[i] = 0;
        else if (if_req && m_starve[i] < SM) m_starve[i]++;
        m_is_if[i] = if_win;
        m_wr[i]    = !if_win && dm_wr;
        m_addr[i]  = if_win ? if_addr : dm_addr;
        if (!if_win) e_d[i] = dm_wdata;
        e_a[i]      = m_addr[i];
        e_cen[i]    = 1'b0;
        e_wen[i]    = !m_wr[i];
        e_busy[i]   = 1'b1;
        m_ackk[i]   = m_wr[i] ? 1 : 1 + lat;
        m_k[i]      = 0;
        m_active[i] = 1'b1;
        if (m_wr[i]) refmem[i][m_addr[i]] = dm_wdata;
      end
    end
  endtask

  task automatic cmp(input int i);
    chk("CEN", i, 32'(cen[i]), 32'(e_cen[i]));
    chk("WEN", i, 32'(wen[i]), 32'(e_wen[i]));
    chk("OEN", i, 32'(oen[i]), 32'd0);
    chk("A", i, 32'(a[i]), 32'(e_a[i]));
    chk("D", i, d[i], e_d[i]);
    chk("if_ack", i, 32'(if_ack[i]), 32'(e_if_ack[i]));
    chk("dm_ack", i, 32'(dm_ack[i]), 32'(e_dm_ack[i]));
    chk("if_rdata", i, if_rdata[i], e_if_rdata[i]);
    chk("dm_rdata", i, dm_rdata[i], e_dm_rdata[i]);
    chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
  endtask

  // One clock: update models at the edge, compare both DUTs on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) cmp(i);
  endtask

  typedef struct {
    bit          is_dm;
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_ticks;
  } vec_t;

  vec_t tbl [9];
  localparam int EXP_ORD [6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    int ord [2][6];
    int nord [2];
    int n;
    int last;
    int nb;
    bit got;
    logic [6:0]  bb_addr [4];
    logic [31:0] bb_data [4];

    // exp_data is the acked port's rdata: read data, or the held dm_rdata on writes.
    tbl[0] = '{1'b1, 1'b1, 7'h05, 32'h20100004, init_word(7'h10), 2};
    tbl[1] = '{1'b0, 1'b0, 7'h05, 32'h00000000, 32'h20100004,     3};
    tbl[2] = '{1'b1, 1'b1, 7'h7F, 32'hDEADBEEF, init_word(7'h10), 2};
    tbl[3] = '{1'b1, 1'b0, 7'h7F, 32'h00000000, 32'hDEADBEEF,     3};
    tbl[4] = '{1'b1, 1'b1, 7'h00, 32'h12345678, 32'hDEADBEEF,     2};
    tbl[5] = '{1'b0, 1'b0, 7'h7F, 32'h00000000, 32'hDEADBEEF,     3};
    tbl[6] = '{1'b1, 1'b0, 7'h00, 32'h00000000, 32'h12345678,     3};
    tbl[7] = '{1'b0, 1'b0, 7'h00, 32'h00000000, 32'h12345678,     3};
    tbl[8] = '{1'b1, 1'b0, 7'h33, 32'h00000000, init_word(7'h33), 3};
    bb_addr = '{7'h05, 7'h7F, 7'h00, 7'h33};
    bb_data = '{32'h20100004, 32'hDEADBEEF, 32'h12345678, init_word(7'h33)};

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 128; j++)
        refmem[i][j] = init_word(7'(j));

    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
    if_addr = 7'h20; dm_addr = 7'h10; dm_wdata = 32'h0;

    // Reset held with both requests pending: nothing may start.
    repeat (2) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk("rst_cen", i, 32'(cen[i]), 32'd1);
        chk("rst_busy", i, 32'(busy[i]), 32'd0);
        chk("rst_acks", i, 32'(if_ack[i] | dm_ack[i]), 32'd0);
        chk("rst_a", i, 32'(a[i]), 32'd0);
      end
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("first_cen", i, 32'(cen[i]), 32'd0);

    // Contention: both requests held, grant order follows the starvation rule.
    nord = '{0, 0};
    for (int i = 0; i < 2; i++) for (int k = 0; k < 6; k++) ord[i][k] = -1;
    for (int c = 0; c < 80 && (nord[0] < 6 || nord[1] < 6); c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk("ack_excl", i, 32'(if_ack[i] & dm_ack[i]), 32'd0);
        if (if_ack[i] || dm_ack[i]) begin
          if (nord[i] < 6) ord[i][nord[i]] = dm_ack[i] ? 1 : 0;
          nord[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("grant_count", i, 32'(nord[i] >= 6), 32'd1);
      for (int k = 0; k < 6; k++) chk("grant_order", i, 32'(ord[i][k]), 32'(EXP_ORD[k]));
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (10) tick();

    // Table of single accesses, timed and checked on the latency-1 instance.
    for (int t = 0; t < 9; t++) begin
      if_req = !tbl[t].is_dm;
      dm_req = tbl[t].is_dm;
      dm_wr  = tbl[t].wr;
      if (tbl[t].is_dm) begin
        dm_addr  = tbl[t].addr;
        dm_wdata = tbl[t].wdata;
      end else begin
        if_addr = tbl[t].addr;
      end
      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        tick();
        n++;
        if (if_ack[0] || dm_ack[0]) got = 1'b1;
      end
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      chk("tbl_ack_seen", t, 32'(got), 32'd1);
      chk("tbl_ack_port", t, 32'(dm_ack[0]), 32'(tbl[t].is_dm));
      chk("tbl_latency", t, 32'(n), 32'(tbl[t].exp_ticks));
      chk("tbl_rdata", t, tbl[t].is_dm ? dm_rdata[0] : if_rdata[0], tbl[t].exp_data);
      repeat (8) tick();
    end

    // Back-to-back fetches: acks four cycles apart, data follows each address.
    if_req = 1'b1; dm_req = 1'b0; if_addr = bb_addr[0];
    nb = 0; last = 0;
    for (int c = 1; c <= 30 && nb < 4; c++) begin
      tick();
      if (if_ack[0]) begin
        chk("bb_rdata", nb, if_rdata[0], bb_data[nb]);
        if (nb > 0) chk("bb_spacing", nb, 32'(c - last), 32'd4);
        last = c;
        nb++;
        if (nb < 4) if_addr = bb_addr[nb];
      end
    end
    chk("bb_count", 0, 32'(nb), 32'd4);
    if_req = 1'b0;
    repeat (10) tick();

    // Reset during the latency-3 read wait, then re-issue from the held request.
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 7'h44;
    repeat (3) tick();
    chk("midrd_busy", 1, 32'(busy[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrd_rst_busy", 1, 32'(busy[1]), 32'd0);
    chk("midrd_rst_cen", 1, 32'(cen[1]), 32'd1);
    chk("midrd_rst_ack", 1, 32'(dm_ack[1]), 32'd0);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (n == 1) chk("midrd_reissue", 1, 32'(cen[1]), 32'd0);
      if (dm_ack[1]) got = 1'b1;
    end
    dm_req = 1'b0;
    chk("midrd_ack_seen", 1, 32'(got), 32'd1);
    chk("midrd_latency", 1, 32'(n), 32'd5);
    chk("midrd_rdata", 1, dm_rdata[1], init_word(7'h44));
    repeat (10) tick();

    // Randomized traffic with occasional resets, checked by the models.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      if_req   = ($urandom_range(0, 3) != 0);
      dm_req   = ($urandom_range(0, 2) != 0);
      dm_wr    = $urandom_range(0, 1) == 1;
      if_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      dm_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      dm_wdata = $urandom;
      tick();
    end
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-SRAM port (CEN/WEN/A/D/Q/OEN interface, word-addressed) between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Sits between the pipelined core's IF/MEM stages and the SRAM macro.
- Arbitrates with fixed data-port priority plus a starvation guard, sequences each access through a registered FSM honouring the SRAM read latency, and returns data with a one-cycle ack pulse.

Parameters:
- AW, 7: SRAM word-address width.
- DW, 32: data width.
- RD_LAT, 1: SRAM read latency in cycles, counted from the sampling edge of the CEN=0 cycle until Q is valid for capture. Legal values are 1 or more.
- STARVE_MAX, 2: maximum number of consecutive lost arbitrations for the fetch port before it is forced to win. Legal values are 1 or more.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch read request (level).
- if_addr  in  AW  fetch word address.
- if_ack  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  DW  fetch read data, valid with if_ack, held until the next if_ack.
- dm_req  in  1  data request (level).
- dm_wr  in  1  1=write, 0=read.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  write data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  data read data, valid with dm_ack on reads, held otherwise (a write does not change it).
- busy  out  1  high whenever the FSM is not in IDLE.
- CEN  out  1  SRAM chip enable, active-low.
- WEN  out  1  SRAM write enable, 0=write, 1=read.
- OEN  out  1  SRAM output enable, tied 0.
- A  out  AW  SRAM address.
- D  out  DW  SRAM write data.
- Q  in  DW  SRAM read data.

Behaviour:
- Reset (rst high at a posedge): next state IDLE. CEN=1, WEN=1, A=0, D=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, starve counter=0, busy=0. Reset wins over every event. An access in flight is dropped with no ack, and the requester must re-request.
- All outputs are registered; OEN is constant 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: at the posedge, sample the requests.
  - If any request is pending, latch the winner's port id, address, write flag and wdata, load A/D/WEN, set CEN=0, and go to ISSUE.
  - If no request is pending, stay in IDLE.
- Arbitration: if only one port requests, it wins. If both request, dm wins unless starve_cnt == STARVE_MAX, in which case if wins.
- Starve counter:
  - Increments, saturating at STARVE_MAX, each time if_req loses.
  - Clears when the fetch port is granted.
  - Unchanged when if_req is low.
- ISSUE: lasts exactly one cycle with CEN=0, and the SRAM samples at its closing edge. At that edge CEN returns to 1 and WEN to 1, while A and D hold.
  - Write: go to RESP.
  - Read: go to WAIT with cnt=RD_LAT.
- WAIT: cnt decrements each edge. At the edge where cnt==1, capture Q into the granted port's rdata and go to RESP.
- RESP: the granted port's ack is high for exactly this cycle, then the FSM returns unconditionally to IDLE.
- Timing, with the request sampled at edge E0:
  - Write: dm_ack is high during cycle [E1,E2).
  - Read: ack is high during [E(1+RD_LAT), E(2+RD_LAT)).
  - A read occupies RD_LAT+3 cycles per access; a write occupies 3.
- Handshake: request fields are latched at grant, so changes after grant are ignored. A req still high in the IDLE cycle after RESP is treated as a new request.
- Acks are mutually exclusive; at most one is high in any cycle.
- Address and data pass through unmodified; there is no wrap or arithmetic on A.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=dm_req=1 -> CEN=1, WEN=1, A=0, acks 0, busy 0 throughout; the first CEN=0 appears in the second cycle after rst falls.
- Fetch read: RD_LAT=1, mem[0x05]=0x20100004, if_req with if_addr=0x05 -> CEN=0/WEN=1/A=0x05 for exactly one cycle, then if_ack for one cycle 3 cycles after the sampling edge with if_rdata=0x20100004.
- Data write then read: dm_wr=1, dm_addr=0x7F, dm_wdata=0xDEADBEEF -> one cycle of CEN=0/WEN=0/A=0x7F/D=0xDEADBEEF, then dm_ack. A following read of 0x7F -> dm_rdata=0xDEADBEEF; dm_rdata is unchanged across the write ack.
- Contention: STARVE_MAX=2, both reqs held high -> grant order dm, dm, if, dm, dm, if; if_ack and dm_ack never overlap.
- Reset mid-read: RD_LAT=3, rst pulsed during WAIT -> no ack, CEN=1, busy=0 next cycle. A req held after release is re-issued from ISSUE, and the ack returns the correct Q.
- Back-to-back: RD_LAT=1, if_req held high -> consecutive if_ack pulses exactly 4 cycles apart, with if_rdata updating on each ack.
